// File: rtl/fir_mac_if.sv
// Sample, result and coefficient-load signals of the fir_mac filter core.
// Sample transfer: a sample moves on a rising edge where in_valid and in_ready are both high; out_valid is a one-cycle pulse, no backpressure.
interface fir_mac_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int AW     = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] x;
  logic              out_valid;
  logic [DATA_W-1:0] y;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_data;

  modport master (
    output in_valid, x, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, x, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/fir_mac.sv
// Time-multiplexed signed FIR: one MAC walks a TAPS-deep delay line per accepted sample.
// FIR_COEF_LOAD_EN: when defined, coefficients are runtime-writable registers; otherwise all equal COEF_RESET.
module fir_mac #(
  parameter int DATA_W     = 8,
  parameter int COEF_W     = 8,
  parameter int TAPS       = 8,
  parameter int SHIFT      = 3,
  parameter int COEF_RESET = 1
) (
  input  logic     clk,
  input  logic     reset,
  fir_mac_if.slave bus,
  output logic     state_dbg
);
  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + AW;
  localparam logic signed [COEF_W-1:0] COEF_INIT = COEF_W'(COEF_RESET);
  localparam logic signed [ACC_W:0] RND_BIAS = (ACC_W+1)'((2**SHIFT) / 2);
  localparam logic signed [ACC_W:0] Y_MAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] Y_MIN = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, MAC = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [AW-1:0]            idx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] d [TAPS];
  logic signed [COEF_W-1:0] coef_cur;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W:0]    rnd_sum;
  logic signed [ACC_W:0]    rounded;
  logic signed [DATA_W-1:0] y_sat;
  logic                     accept;
  logic                     last;

  assign bus.in_ready = (state_q == IDLE);
  assign accept       = bus.in_valid & bus.in_ready;
  assign last         = (state_q == MAC) && (idx == AW'(TAPS - 1));
  assign state_dbg    = state_q;

`ifdef FIR_COEF_LOAD_EN
  logic signed [COEF_W-1:0] c [TAPS];

  // Writes land only in IDLE, so a same-edge sample already sees the new value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) c[i] <= COEF_INIT;
    end else if (bus.coef_we && bus.in_ready && (int'(bus.coef_addr) < TAPS)) begin
      c[bus.coef_addr] <= bus.coef_data;
    end
  end

  assign coef_cur = c[idx];
`else
  logic unused_coef;
  assign unused_coef = ^{bus.coef_we, bus.coef_addr, bus.coef_data};
  assign coef_cur    = COEF_INIT;
`endif

  assign prod    = d[idx] * coef_cur;
  assign acc_sum = acc + {{AW{prod[PROD_W-1]}}, prod};
  assign rnd_sum = {acc_sum[ACC_W-1], acc_sum} + RND_BIAS;
  assign rounded = rnd_sum >>> SHIFT;

  always_comb begin
    y_sat = rounded[DATA_W-1:0];
    if (rounded > Y_MAX) begin
      y_sat = Y_MAX[DATA_W-1:0];
    end else if (rounded < Y_MIN) begin
      y_sat = Y_MIN[DATA_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = MAC;
      MAC:     if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The final product is folded in combinationally, so y updates on the last MAC edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx           <= '0;
      acc           <= '0;
      bus.y         <= '0;
      bus.out_valid <= 1'b0;
      for (int i = 0; i < TAPS; i++) d[i] <= '0;
    end else begin
      bus.out_valid <= last;
      if (accept) begin
        d[0] <= bus.x;
        for (int i = 1; i < TAPS; i++) d[i] <= d[i-1];
        acc <= '0;
        idx <= '0;
      end else if (state_q == MAC) begin
        acc <= acc_sum;
        idx <= idx + AW'(1);
        if (last) bus.y <= y_sat;
      end
    end
  end
endmodule

// File: tb/tb_fir_mac.sv
// Bench for fir_mac: cycle-level reference model with result queue, per-cycle compare, literal spot checks.
module tb_fir_mac;
  localparam int DATA_W     = 8;
  localparam int COEF_W     = 8;
  localparam int TAPS       = 8;
  localparam int SHIFT      = 3;
  localparam int COEF_RESET = 1;
  localparam int AW         = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic state_dbg;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   checking = 1'b0;

  fir_mac_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .AW(AW)) bus ();

  fir_mac #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .SHIFT(SHIFT), .COEF_RESET(COEF_RESET)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: sample history, coefficient table, busy countdown, result queue
  int                hist [TAPS];
  int                mc [TAPS];
  int                busy = 0;
  logic [DATA_W-1:0] m_y = '0;
  bit                m_ov = 1'b0;
  logic [DATA_W-1:0] exp_q[$];

  function automatic logic [DATA_W-1:0] model_out();
    longint s = 0;
    for (int i = 0; i < TAPS; i++) s += longint'(hist[i]) * longint'(mc[i]);
    if (SHIFT > 0) s = (s + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    if (s > 2**(DATA_W-1) - 1) s = 2**(DATA_W-1) - 1;
    if (s < -(2**(DATA_W-1))) s = -(2**(DATA_W-1));
    return s[DATA_W-1:0];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      busy = 0;
      m_y  = '0;
      m_ov = 1'b0;
      exp_q.delete();
      for (int i = 0; i < TAPS; i++) begin
        hist[i] = 0;
        mc[i]   = COEF_RESET;
      end
    end else begin
      m_ov = 1'b0;
      if (busy != 0) begin
        busy--;
        if (busy == 0) begin
          m_y  = exp_q.pop_front();
          m_ov = 1'b1;
        end
      end else begin
`ifdef FIR_COEF_LOAD_EN
        if (bus.coef_we && int'(bus.coef_addr) < TAPS) mc[bus.coef_addr] = int'($signed(bus.coef_data));
`endif
        if (bus.in_valid) begin
          for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
          hist[0] = int'($signed(bus.x));
          exp_q.push_back(model_out());
          busy = TAPS;
        end
      end
    end
  end

  task automatic check(input string name, input logic signed [31:0] got, input logic signed [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // scoreboard compare, every cycle
  always @(negedge clk) begin
    if (checking) begin
      check("in_ready", bus.in_ready, busy == 0);
      check("out_valid", bus.out_valid, m_ov);
      check("y", $signed(bus.y), $signed(m_y));
      check("state_dbg", state_dbg, busy != 0);
    end
  end

  // driver tasks
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1) begin
      n++;
      if (n > 40) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: got in_ready=%b expected 1 within 40 cycles", bus.in_ready);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] v);
    wait_ready();
    bus.x        = v;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic [COEF_W-1:0] v);
    wait_ready();
    bus.coef_we   = 1'b1;
    bus.coef_addr = a;
    bus.coef_data = v;
    @(posedge clk);
    #1 bus.coef_we = 1'b0;
  endtask

  task automatic get_result(output logic [DATA_W-1:0] r);
    int n = 0;
    r = '0;
    @(negedge clk);
    while (bus.out_valid !== 1'b1) begin
      n++;
      if (n > 20) begin
        checks++;
        errors++;
        $display("FAIL result_timeout: got out_valid=%b expected 1 within 20 cycles", bus.out_valid);
        return;
      end
      @(negedge clk);
    end
    r = bus.y;
  endtask

  task automatic send_get(input logic [DATA_W-1:0] v, input int want, input string name);
    logic [DATA_W-1:0] r;
    send(v);
    get_result(r);
    check(name, $signed(r), want);
  endtask

  task automatic flush();
    for (int i = 0; i < TAPS; i++) send('0);
  endtask

  int first_acc, prev_acc, lat;

  initial begin
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;

    // reset for 2 cycles
    @(posedge clk);
    #1 checking = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_y", $signed(bus.y), 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    repeat (5) @(negedge clk);

    // impulse response with default coefficients
    send_get(8'd64, 8, "imp64_head");
    for (int i = 0; i < TAPS - 1; i++) send_get(8'd0, 8, "imp64_tail");
    send_get(8'd0, 0, "imp64_end");
    flush();
    send_get(8'd3, 0, "imp3_round_down");
    flush();
    send_get(8'd4, 1, "imp4_round_up");

    // in_valid held high continuously
    wait_ready();
    bus.in_valid = 1'b1;
    bus.x = DATA_W'($urandom);
    first_acc = -1;
    prev_acc = -1;
    lat = -1;
    for (int k = 0; k < 50; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.out_valid === 1'b1 && lat < 0 && first_acc >= 0) lat = cyc - first_acc;
      if (bus.in_ready === 1'b1) begin
        if (prev_acc >= 0) check("accept_interval", cyc + 1 - prev_acc, TAPS + 1);
        prev_acc = cyc + 1;
        if (first_acc < 0) first_acc = cyc + 1;
      end
      @(posedge clk);
      #1 bus.x = DATA_W'($urandom);
    end
    bus.in_valid = 1'b0;
    check("first_latency", lat, TAPS);

    // coefficient load, and a write during MAC
    flush();
    write_coef(3'd0, 8'd16);
    for (int i = 1; i < TAPS; i++) write_coef(AW'(i), 8'd0);
`ifdef FIR_COEF_LOAD_EN
    send_get(8'd10, 20, "coef_load");
`else
    send_get(8'd10, 1, "coef_load_ignored");
`endif
    begin
      logic [DATA_W-1:0] r;
      send(8'd10);
      bus.coef_we   = 1'b1;
      bus.coef_addr = 3'd0;
      bus.coef_data = 8'd0;
      @(posedge clk);
      #1 bus.coef_we = 1'b0;
      get_result(r);
`ifdef FIR_COEF_LOAD_EN
      check("coef_write_in_mac_dropped", $signed(r), 20);
`else
      check("coef_write_in_mac_dropped", $signed(r), 3);
`endif
    end

    // saturation at both rails
    for (int i = 0; i < TAPS; i++) write_coef(AW'(i), 8'd127);
    for (int i = 0; i < TAPS - 1; i++) send(8'd127);
    send_get(8'd127, 127, "sat_pos");
    for (int i = 0; i < TAPS - 1; i++) send(8'h80);
    send_get(8'h80, -128, "sat_neg");

    // reset during the 4th MAC cycle
    send(8'd100);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midmac_out_valid", bus.out_valid, 0);
    check("midmac_in_ready", bus.in_ready, 1);
    check("midmac_y", $signed(bus.y), 0);
    repeat (TAPS + 2) @(negedge clk);
    send_get(8'd64, 8, "post_reset_imp64");

    // randomized traffic with coefficient writes in idle and during MAC
    for (int k = 0; k < 120; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      if ($urandom_range(0, 4) == 0) write_coef(AW'($urandom), COEF_W'($urandom));
      wait_ready();
      bus.x = DATA_W'($urandom);
      bus.in_valid = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        bus.coef_we   = 1'b1;
        bus.coef_addr = AW'($urandom);
        bus.coef_data = COEF_W'($urandom);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.coef_we  = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        bus.coef_we   = 1'b1;
        bus.coef_addr = AW'($urandom);
        bus.coef_data = COEF_W'($urandom);
        @(posedge clk);
        #1 bus.coef_we = 1'b0;
      end
    end
    wait_ready();
    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
